load_align_unit: RTL and testbench

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/load_align_pkg.sv | 37 +++
 rtl/load_extend_core.sv | 74 +++++++
 rtl/load_align_unit.sv | 147 ++++++++++++++
 tb/tb_load_align_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/load_align_pkg.sv
// load_align_pkg
// Shared definitions for the load alignment unit: the load-type encoding and
// the issue-time error check.
// Optional feature macro: LOAD_UNALIGNED_EN (enables LWL/LWR; when undefined,
// those encodings are treated as reserved and flagged as errors).
package load_align_pkg;

   typedef enum logic [2:0] {
      LF_LB   = 3'b000,
      LF_LBU  = 3'b001,
      LF_LH   = 3'b010,
      LF_LHU  = 3'b011,
      LF_LW   = 3'b100,
      LF_LWL  = 3'b101,
      LF_LWR  = 3'b110,
      LF_RSVD = 3'b111
   } load_func_e;

   // Address-error / illegal-encoding flag, evaluated once when a load is queued.
   function automatic logic load_err(input logic [2:0] func, input logic [1:0] addr_lo);
      logic err;
      case (func)
         LF_LB, LF_LBU: err = 1'b0;
         LF_LH, LF_LHU: err = addr_lo[0];
         LF_LW:         err = (addr_lo != 2'b00);
`ifdef LOAD_UNALIGNED_EN
         LF_LWL, LF_LWR: err = 1'b0;
`else
         LF_LWL, LF_LWR: err = 1'b1;
`endif
         LF_RSVD:       err = 1'b1;
         default:       err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/load_extend_core.sv
// load_extend_core
// Purely combinational byte/halfword select, sign/zero extension and LWL/LWR
// merge of one memory word for the load at the head of the queue.
// Ports:
//   func    [2:0]  load type of the head entry
//   addr_lo [1:0]  byte offset of the head entry
//   err            head entry is flagged illegal (forces data to zero)
//   rt_old  [31:0] old rt value for merges (present only with LOAD_UNALIGNED_EN)
//   rdata   [31:0] aligned memory word
//   data    [31:0] aligned / extended / merged result
// Optional feature macro: LOAD_UNALIGNED_EN.
module load_extend_core
   import load_align_pkg::*;
(
   input  logic [2:0]  func,
   input  logic [1:0]  addr_lo,
   input  logic        err,
`ifdef LOAD_UNALIGNED_EN
   input  logic [31:0] rt_old,
`endif
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;
`ifdef LOAD_UNALIGNED_EN
   logic [4:0]  lwl_sh_s;
   logic [4:0]  lwr_sh_s;

   // 8*(3-a) equals {~a,000} for a 2-bit offset; 8*a equals {a,000}.
   assign lwl_sh_s = {~addr_lo, 3'b000};
   assign lwr_sh_s = {addr_lo, 3'b000};
`endif

   // Pick the addressed byte and halfword out of the memory word.
   always_comb begin
      byte_s = rdata[7:0];
      case (addr_lo)
         2'b00:   byte_s = rdata[7:0];
         2'b01:   byte_s = rdata[15:8];
         2'b10:   byte_s = rdata[23:16];
         2'b11:   byte_s = rdata[31:24];
         default: byte_s = rdata[7:0];
      endcase
      if (addr_lo[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
   end

   // Build the writeback value; illegal entries always produce zero.
   always_comb begin
      data = 32'h0000_0000;
      if (err) begin
         data = 32'h0000_0000;
      end else begin
         case (func)
            LF_LB:   data = {{24{byte_s[7]}}, byte_s};
            LF_LBU:  data = {24'h00_0000, byte_s};
            LF_LH:   data = {{16{half_s[15]}}, half_s};
            LF_LHU:  data = {16'h0000, half_s};
            LF_LW:   data = rdata;
`ifdef LOAD_UNALIGNED_EN
            LF_LWL:  data = (rdata << lwl_sh_s) | (rt_old & ~(32'hFFFF_FFFF << lwl_sh_s));
            LF_LWR:  data = (rdata >> lwr_sh_s) | (rt_old & ~(32'hFFFF_FFFF >> lwr_sh_s));
`endif
            default: data = 32'h0000_0000;
         endcase
      end
   end

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit
// Holds issued loads in an in-order queue until their memory word returns,
// then aligns/extends the word and presents it on a registered writeback port.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   iss_valid/iss_ready          issue handshake (iss_ready = queue not full)
//   iss_func, iss_addr_lo,
//   iss_tag, iss_rt_old          load type, byte offset, destination tag, old rt
//   mem_valid/mem_ready,
//   mem_rdata                    one in-order read beat per queued load
//   out_valid/out_ready,
//   out_data, out_tag, out_err   registered writeback result
//   occupancy                    number of queued loads
// Optional feature macro: LOAD_UNALIGNED_EN (LWL/LWR merge support; when
// undefined, iss_rt_old is ignored and not stored).
module load_align_unit
   import load_align_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     iss_valid,
   output logic                     iss_ready,
   input  logic [2:0]               iss_func,
   input  logic [1:0]               iss_addr_lo,
   input  logic [TAG_W-1:0]         iss_tag,
   input  logic [31:0]              iss_rt_old,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [31:0]              mem_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_err,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [2:0]       func_q_r  [DEPTH];
   logic [1:0]       addr_q_r  [DEPTH];
   logic [TAG_W-1:0] tag_q_r   [DEPTH];
   logic             err_q_r   [DEPTH];
`ifdef LOAD_UNALIGNED_EN
   logic [31:0]      rt_q_r    [DEPTH];
`else
   logic             unused_rt_old_s;
`endif

   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] occ_r;
   logic             out_valid_r;
   logic [31:0]      out_data_r;
   logic [TAG_W-1:0] out_tag_r;
   logic             out_err_r;

   logic             full_s;
   logic             push_s;
   logic             pop_s;
   logic [31:0]      result_s;

`ifndef LOAD_UNALIGNED_EN
   assign unused_rt_old_s = ^iss_rt_old;
`endif

   // Readiness is based on registered occupancy only, so a same-cycle pop
   // cannot open a full queue and a same-cycle push cannot be matched.
   assign full_s    = (occ_r == CNT_W'(DEPTH));
   assign iss_ready = !full_s;
   assign mem_ready = (occ_r != {CNT_W{1'b0}}) && (!out_valid_r || out_ready);
   assign push_s    = iss_valid && iss_ready;
   assign pop_s     = mem_valid && mem_ready;

   assign occupancy = occ_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_tag   = out_tag_r;
   assign out_err   = out_err_r;

   // Queue storage: write the issued load into the tail slot.
   always_ff @(posedge clk) begin
      if (push_s) begin
         func_q_r[wr_ptr_r] <= iss_func;
         addr_q_r[wr_ptr_r] <= iss_addr_lo;
         tag_q_r[wr_ptr_r]  <= iss_tag;
         err_q_r[wr_ptr_r]  <= load_err(iss_func, iss_addr_lo);
`ifdef LOAD_UNALIGNED_EN
         rt_q_r[wr_ptr_r]   <= iss_rt_old;
`endif
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         occ_r    <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + CNT_W'(1);
            2'b01:   occ_r <= occ_r - CNT_W'(1);
            default: occ_r <= occ_r;
         endcase
      end
   end

   load_extend_core u_core (
      .func    (func_q_r[rd_ptr_r]),
      .addr_lo (addr_q_r[rd_ptr_r]),
      .err     (err_q_r[rd_ptr_r]),
`ifdef LOAD_UNALIGNED_EN
      .rt_old  (rt_q_r[rd_ptr_r]),
`endif
      .rdata   (mem_rdata),
      .data    (result_s)
   );

   // Writeback register: load on a popped beat, hold while stalled, drop when taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= 32'h0000_0000;
         out_tag_r   <= {TAG_W{1'b0}};
         out_err_r   <= 1'b0;
      end else if (pop_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= result_s;
         out_tag_r   <= tag_q_r[rd_ptr_r];
         out_err_r   <= err_q_r[rd_ptr_r];
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;

   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   localparam logic [2:0] F_LB   = 3'b000;
   localparam logic [2:0] F_LBU  = 3'b001;
   localparam logic [2:0] F_LH   = 3'b010;
   localparam logic [2:0] F_LHU  = 3'b011;
   localparam logic [2:0] F_LW   = 3'b100;
   localparam logic [2:0] F_LWL  = 3'b101;
   localparam logic [2:0] F_LWR  = 3'b110;
   localparam logic [2:0] F_RSVD = 3'b111;

`ifdef LOAD_UNALIGNED_EN
   localparam logic UA_ERR = 1'b0;
`else
   localparam logic UA_ERR = 1'b1;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             iss_valid = 1'b0;
   logic             iss_ready;
   logic [2:0]       iss_func = 3'b000;
   logic [1:0]       iss_addr_lo = 2'b00;
   logic [TAG_W-1:0] iss_tag = '0;
   logic [31:0]      iss_rt_old = 32'h0;
   logic             mem_valid = 1'b0;
   logic             mem_ready;
   logic [31:0]      mem_rdata = 32'h0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;
   logic [2:0]       occupancy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_align_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func),
      .iss_addr_lo(iss_addr_lo), .iss_tag(iss_tag), .iss_rt_old(iss_rt_old),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_err(out_err), .occupancy(occupancy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] f, input logic [1:0] a, input logic [TAG_W-1:0] t, input logic [31:0] rt);
      iss_valid = 1'b1; iss_func = f; iss_addr_lo = a; iss_tag = t; iss_rt_old = rt;
      step();
      iss_valid = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d);
      mem_valid = 1'b1; mem_rdata = d;
      step();
      mem_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", occupancy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      checks++; if ({out_data, out_tag, out_err} !== {32'h0, 5'd0, 1'b0}) begin errors++; $display("FAIL reset_out_fields: got %h/%h/%b exp 0/0/0", out_data, out_tag, out_err); end
      checks++; if ({iss_ready, mem_ready} !== 2'b10) begin errors++; $display("FAIL reset_ready: got iss=%b mem=%b exp 1/0", iss_ready, mem_ready); end
   endtask

   // Table of {func, addr, rt, rdata} -> {err, data}, checked one cycle after the beat.
   task automatic test_extend();
      logic [2:0]  f  [22] = '{F_LB, F_LBU, F_LB, F_LB, F_LBU,
                               F_LHU, F_LH, F_LH, F_LHU, F_LH, F_LHU,
                               F_LW, F_LW, F_LW, F_RSVD,
                               F_LWL, F_LWR, F_LWL, F_LWL, F_LWL, F_LWR, F_LWR};
      logic [1:0]  a  [22] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd1,
                               2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3,
                               2'd0, 2'd2, 2'd1, 2'd0,
                               2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd0, 2'd3};
      logic [31:0] rd [22] = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234,
                               32'h80010000, 32'h80010000, 32'h0000F00D, 32'h0000F00D, 32'h80010000, 32'h80010000,
                               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                               32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD};
      logic [31:0] ed [22] = '{32'hFFFFFF80, 32'h00000080, 32'h00000034, 32'hFFFFFFFF, 32'h00000012,
                               32'h00008001, 32'hFFFF8001, 32'hFFFFF00D, 32'h0000F00D, 32'h0, 32'h0,
                               32'hDEADBEEF, 32'h0, 32'h0, 32'h0,
                               32'hCCDD3344, 32'h1122AABB, 32'hDD223344, 32'hBBCCDD44, 32'hAABBCCDD, 32'hAABBCCDD, 32'h112233AA};
      logic        ee [22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b1, 1'b1, 1'b1,
                               UA_ERR, UA_ERR, UA_ERR, UA_ERR, UA_ERR, UA_ERR, UA_ERR};
      logic [31:0] exp_d;
      logic [TAG_W-1:0] t;
      for (int i = 0; i < 22; i++) begin
         t = TAG_W'(i + 1);
         exp_d = ee[i] ? 32'h0 : ed[i];
         issue(f[i], a[i], t, 32'h11223344);
         checks++; if ({occupancy, mem_ready} !== {3'd1, 1'b1}) begin errors++; $display("FAIL ext%0d_queued: got occ=%0d mrdy=%b exp 1/1", i, occupancy, mem_ready); end
         beat(rd[i]);
         checks++;
         if ({out_valid, out_err, out_tag, out_data, occupancy} !== {1'b1, ee[i], t, exp_d, 3'd0}) begin
            errors++;
            $display("FAIL ext%0d_result: got v=%b e=%b tag=%0d data=%h occ=%0d exp v=1 e=%b tag=%0d data=%h occ=0",
                     i, out_valid, out_err, out_tag, out_data, occupancy, ee[i], t, exp_d);
         end
         step();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ext%0d_drop: got out_valid=%b exp 0", i, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      issue(F_LW, 2'd0, 5'd5, 32'h0);
      iss_valid = 1'b1; iss_func = F_LW; iss_addr_lo = 2'd0; iss_tag = 5'd6;
      mem_valid = 1'b1; mem_rdata = 32'h55555555;
      step();
      iss_valid = 1'b0; mem_valid = 1'b0;
      checks++; if ({occupancy, out_valid, out_tag, out_data} !== {3'd1, 1'b1, 5'd5, 32'h55555555}) begin errors++; $display("FAIL b2b_pushpop: got occ=%0d v=%b tag=%0d data=%h exp 1/1/5/55555555", occupancy, out_valid, out_tag, out_data); end
      beat(32'h66666666);
      checks++; if ({occupancy, out_valid, out_tag, out_data} !== {3'd0, 1'b1, 5'd6, 32'h66666666}) begin errors++; $display("FAIL b2b_second: got occ=%0d v=%b tag=%0d data=%h exp 0/1/6/66666666", occupancy, out_valid, out_tag, out_data); end
      step();
   endtask

   task automatic test_full();
      iss_valid = 1'b1; iss_func = F_LW; iss_addr_lo = 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
         iss_tag = TAG_W'(10 + i);
         step();
      end
      iss_valid = 1'b0;
      checks++; if ({occupancy, iss_ready, mem_ready} !== {3'd4, 1'b0, 1'b1}) begin errors++; $display("FAIL full_state: got occ=%0d irdy=%b mrdy=%b exp 4/0/1", occupancy, iss_ready, mem_ready); end
      iss_valid = 1'b1; iss_tag = 5'd14;
      mem_valid = 1'b1; mem_rdata = 32'd10;
      #1;
      checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL full_pop_not_ready: got iss_ready=%b exp 0", iss_ready); end
      step();
      mem_valid = 1'b0;
      checks++; if ({occupancy, out_valid, out_tag, out_data} !== {3'd3, 1'b1, 5'd10, 32'd10}) begin errors++; $display("FAIL full_pop: got occ=%0d v=%b tag=%0d data=%h exp 3/1/10/a", occupancy, out_valid, out_tag, out_data); end
      step();
      iss_valid = 1'b0;
      checks++; if ({occupancy, iss_ready} !== {3'd4, 1'b0}) begin errors++; $display("FAIL full_refill: got occ=%0d irdy=%b exp 4/0", occupancy, iss_ready); end
      mem_valid = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         mem_rdata = 32'(11 + k);
         step();
         checks++; if ({out_valid, out_tag, out_data} !== {1'b1, 5'(11 + k), 32'(11 + k)}) begin errors++; $display("FAIL full_order%0d: got v=%b tag=%0d data=%h exp 1/%0d/%h", k, out_valid, out_tag, out_data, 11 + k, 11 + k); end
      end
      mem_valid = 1'b0;
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL full_drained: got occ=%0d exp 0", occupancy); end
      step();
   endtask

   task automatic test_backpressure();
      issue(F_LW, 2'd0, 5'd20, 32'h0);
      issue(F_LW, 2'd0, 5'd21, 32'h0);
      out_ready = 1'b0;
      beat(32'hA0A0A0A0);
      mem_valid = 1'b1; mem_rdata = 32'hBBBBBBBB;
      for (int c = 0; c < 3; c++) begin
         checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL bp_mem_ready%0d: got %b exp 0", c, mem_ready); end
         step();
         checks++; if ({out_valid, out_tag, out_data, out_err, occupancy} !== {1'b1, 5'd20, 32'hA0A0A0A0, 1'b0, 3'd1}) begin errors++; $display("FAIL bp_hold%0d: got v=%b tag=%0d data=%h e=%b occ=%0d exp 1/20/a0a0a0a0/0/1", c, out_valid, out_tag, out_data, out_err, occupancy); end
      end
      out_ready = 1'b1;
      #1;
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b exp 1", mem_ready); end
      step();
      mem_valid = 1'b0;
      checks++; if ({out_valid, out_tag, out_data, occupancy} !== {1'b1, 5'd21, 32'hBBBBBBBB, 3'd0}) begin errors++; $display("FAIL bp_next: got v=%b tag=%0d data=%h occ=%0d exp 1/21/bbbbbbbb/0", out_valid, out_tag, out_data, occupancy); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b exp 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < DEPTH; i++) begin
         issue(F_LW, 2'd0, TAG_W'(1 + i), 32'h0);
      end
      out_ready = 1'b0;
      beat(32'h12345678);
      checks++; if ({out_valid, occupancy} !== {1'b1, 3'd3}) begin errors++; $display("FAIL rmid_pre: got v=%b occ=%0d exp 1/3", out_valid, occupancy); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if ({occupancy, out_valid, out_tag, out_data, out_err} !== {3'd0, 1'b0, 5'd0, 32'h0, 1'b0}) begin errors++; $display("FAIL rmid_clear: got occ=%0d v=%b tag=%0d data=%h e=%b exp 0/0/0/0/0", occupancy, out_valid, out_tag, out_data, out_err); end
      out_ready = 1'b1;
      mem_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
      #1;
      checks++; if ({iss_ready, mem_ready} !== 2'b10) begin errors++; $display("FAIL rmid_ready: got iss=%b mem=%b exp 1/0", iss_ready, mem_ready); end
      step(); step();
      mem_valid = 1'b0;
      checks++; if ({out_valid, occupancy} !== {1'b0, 3'd0}) begin errors++; $display("FAIL rmid_ignore: got v=%b occ=%0d exp 0/0", out_valid, occupancy); end
   endtask

   initial begin
      test_reset();
      test_extend();
      test_back_to_back();
      test_full();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
